// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control sequencer (optional bne support: MC_BNE_EN)
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    logic [3:0] state_r;
    logic [3:0] state_d;
    logic [3:0] decode_next;
    logic       op_known;
    logic [1:0] aluop;
    logic       pcupdate;
    logic       branch;
    logic       take;

    assign state = state_r;

    // State register; reset drops straight back to FETCH without a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_d;
        end
    end

    // Opcode dispatch used when leaving DECODE; unknown opcodes restart at FETCH
    always_comb begin
        decode_next = FETCH;
        op_known    = 1'b1;
        case (opcode)
            OP_LOAD, OP_STORE: decode_next = MEMADR;
            OP_RTYPE:          decode_next = EXECUTER;
            OP_ITYPE:          decode_next = EXECUTEI;
            OP_BRANCH:         decode_next = BRANCH;
            OP_JAL:            decode_next = JAL;
            default:           op_known    = 1'b0;
        endcase
    end

    // Next-state sequencing; unused codes fall back to FETCH
    always_comb begin
        state_d = FETCH;
        case (state_r)
            FETCH:    state_d = DECODE;
            DECODE:   state_d = decode_next;
            MEMADR:   state_d = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    // Moore control word for each state; anything not set stays inactive
    always_comb begin
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        illegal   = 1'b0;
        aluop     = ALUOP_ADD;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        case (state_r)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcupdate  = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                illegal = ~op_known;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                aluop   = ALUOP_FUNC;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = ALUOP_FUNC;
            end
            ALUWB: begin
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcupdate = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ALU decoder; only R-type (opcode[5] set) can turn funct3=000 into sub
    always_comb begin
        ALUControl = 3'b000;
        case (aluop)
            ALUOP_SUB: ALUControl = 3'b001;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  ALUControl = (opcode[5] & funct7_5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        case (opcode)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

`ifdef MC_BNE_EN
    // Branch condition: beq on zero, bne on not-zero, other funct3 never taken
    always_comb begin
        case (funct3)
            3'b000:  take = zero;
            3'b001:  take = ~zero;
            default: take = 1'b0;
        endcase
    end
`else
    // Branch condition: every branch is treated as beq
    always_comb begin
        take = zero;
    end
`endif

    assign PCWrite = pcupdate | (branch & take);

endmodule
